branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 162 ++++++++++++++++
 tb/tb_branch_predictor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               counters. It predicts the fetch PC combinationally and
//               learns from branches resolved in execute. A mispredict
//               redirect is registered one cycle after the resolution.
// Ports       : clk, rst_n (synchronous, active low)
//               fetch_pc -> pred_taken, pred_target      (combinational)
//               upd_valid, upd_pc, upd_taken, upd_target,
//               upd_pred_taken, upd_pred_target           (execute feedback)
//               mispredict, correct_pc                    (registered redirect)
//               stat_branches, stat_mispredicts  (only when BP_STATS_EN is
//                                                 defined)
// Options     : `define BP_STATS_EN adds saturating 32-bit event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [DATA_WIDTH-1:0] pred_target,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_pred_taken,
    input  logic [DATA_WIDTH-1:0] upd_pred_target,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] correct_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int                  c_ENTRIES = 1 << INDEX_BITS;
    localparam int                  c_TAG_W   = DATA_WIDTH - INDEX_BITS - 2;
    localparam logic [DATA_WIDTH-1:0] c_PC_STEP = DATA_WIDTH'(4);
    localparam logic [1:0]          c_CTR_RESET = 2'b01;
    localparam logic [1:0]          c_CTR_ALLOC = 2'b10;

    // Table storage
    logic                  r_valid  [c_ENTRIES];
    logic [c_TAG_W-1:0]    r_tag    [c_ENTRIES];
    logic [DATA_WIDTH-1:0] r_target [c_ENTRIES];
    logic [1:0]            r_ctr    [c_ENTRIES];

    logic                  r_mispredict;
    logic [DATA_WIDTH-1:0] r_correct_pc;

    // Fetch-side lookup (reads the table as it stood before this edge)
    logic [INDEX_BITS-1:0] w_fetch_idx;
    logic [c_TAG_W-1:0]    w_fetch_tag;
    logic                  w_fetch_hit;

    assign w_fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign w_fetch_tag = fetch_pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_fetch_hit = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);

    assign pred_taken  = w_fetch_hit && r_ctr[w_fetch_idx][1];
    assign pred_target = pred_taken ? r_target[w_fetch_idx] : fetch_pc + c_PC_STEP;

    // Update-side lookup
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [c_TAG_W-1:0]    w_upd_tag;
    logic                  w_upd_hit;
    logic [1:0]            w_upd_ctr;
    logic [1:0]            w_ctr_next;
    logic                  w_mispredict;

    assign w_upd_idx = upd_pc[INDEX_BITS+1:2];
    assign w_upd_tag = upd_pc[DATA_WIDTH-1:INDEX_BITS+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_ctr = r_ctr[w_upd_idx];

    // Saturating step: taken moves toward 11, not-taken toward 00
    always_comb begin
        w_ctr_next = w_upd_ctr;
        if (upd_taken) begin
            if (w_upd_ctr != 2'b11) begin
                w_ctr_next = w_upd_ctr + 2'd1;
            end
        end else begin
            if (w_upd_ctr != 2'b00) begin
                w_ctr_next = w_upd_ctr - 2'd1;
            end
        end
    end

    // A wrong target only matters when both the prediction and the outcome
    // were taken; a not-taken outcome always falls through to pc+4.
    assign w_mispredict = upd_valid &&
                          ((upd_pred_taken != upd_taken) ||
                           (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_CTR_RESET;
            end
            r_mispredict <= 1'b0;
            r_correct_pc <= '0;
        end else begin
            if (upd_valid) begin
                if (w_upd_hit) begin
                    r_ctr[w_upd_idx] <= w_ctr_next;
                    if (upd_taken) begin
                        r_target[w_upd_idx] <= upd_target;
                    end
                end else if (upd_taken) begin
                    // Allocation evicts whatever occupied this index
                    r_valid[w_upd_idx]  <= 1'b1;
                    r_tag[w_upd_idx]    <= w_upd_tag;
                    r_target[w_upd_idx] <= upd_target;
                    r_ctr[w_upd_idx]    <= c_CTR_ALLOC;
                end
            end
            r_mispredict <= w_mispredict;
            if (w_mispredict) begin
                r_correct_pc <= upd_taken ? upd_target : upd_pc + c_PC_STEP;
            end
        end
    end

    assign mispredict = r_mispredict;
    assign correct_pc = r_correct_pc;

`ifdef BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // The mispredict counter advances on the same edge that raises
    // mispredict, so both become visible together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (upd_valid && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed, table-driven self-checking bench for
//               branch_predictor (DATA_WIDTH=32, INDEX_BITS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;

    branch_predictor #(
        .DATA_WIDTH (32),
        .INDEX_BITS (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_pc        (fetch_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fetch_pc;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        upd_pred_taken;
        logic [31:0] upd_pred_target;
        logic        exp_pred_taken;     // before the edge
        logic [31:0] exp_pred_target;    // before the edge
        logic        exp_mispredict;     // after the edge
        logic [31:0] exp_correct_pc;     // after the edge
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] f, input logic uv, input logic [31:0] up,
                       input logic ut, input logic [31:0] utg, input logic upt,
                       input logic [31:0] uptg, input logic ept, input logic [31:0] eptg,
                       input logic em, input logic [31:0] ecp);
        vec_t v;
        v.fetch_pc = f;        v.upd_valid = uv;       v.upd_pc = up;
        v.upd_taken = ut;      v.upd_target = utg;     v.upd_pred_taken = upt;
        v.upd_pred_target = uptg;
        v.exp_pred_taken = ept; v.exp_pred_target = eptg;
        v.exp_mispredict = em;  v.exp_correct_pc = ecp;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
    endtask

    int exp_branches = 0;
    int exp_misp     = 0;

    initial begin
        rst_n = 1'b0;
        fetch_pc = 32'h100;
        idle_inputs();

        //  fetch        uv  upd_pc      ut  upd_tgt      upt upd_ptgt      ept  ept_tgt       em  ecp
        add(32'h100,     0, 32'h0,       0, 32'h0,        0, 32'h0,         0, 32'h104,       0, 32'h0);
        add(32'h100,     1, 32'h100,     1, 32'h200,      0, 32'h104,       0, 32'h104,       1, 32'h200);
        add(32'h100,     0, 32'h0,       0, 32'h0,        0, 32'h0,         1, 32'h200,       0, 32'h200);
        add(32'h100,     1, 32'h100,     1, 32'h200,      1, 32'h200,       1, 32'h200,       0, 32'h200);
        add(32'h100,     1, 32'h100,     1, 32'h200,      1, 32'h200,       1, 32'h200,       0, 32'h200);
        add(32'h100,     1, 32'h100,     1, 32'h200,      1, 32'h200,       1, 32'h200,       0, 32'h200);
        add(32'h100,     1, 32'h100,     0, 32'h0,        1, 32'h200,       1, 32'h200,       1, 32'h104);
        add(32'h100,     1, 32'h100,     0, 32'h0,        1, 32'h200,       1, 32'h200,       1, 32'h104);
        add(32'h100,     0, 32'h0,       0, 32'h0,        0, 32'h0,         0, 32'h104,       0, 32'h104);
        // taken/taken with a wrong target; same-cycle fetch still sees old state
        add(32'h100,     1, 32'h100,     1, 32'h280,      1, 32'h200,       0, 32'h104,       1, 32'h280);
        add(32'h100,     0, 32'h0,       0, 32'h0,        0, 32'h0,         1, 32'h280,       0, 32'h280);
        // conflicting tag at index 0 evicts 0x100
        add(32'h140,     1, 32'h140,     1, 32'h300,      0, 32'h144,       0, 32'h144,       1, 32'h300);
        add(32'h100,     0, 32'h0,       0, 32'h0,        0, 32'h0,         0, 32'h104,       0, 32'h300);
        add(32'h140,     0, 32'h0,       0, 32'h0,        0, 32'h0,         1, 32'h300,       0, 32'h300);
        // miss + not taken: no allocation
        add(32'h140,     1, 32'h180,     0, 32'h0,        0, 32'h184,       1, 32'h300,       0, 32'h300);
        add(32'h180,     0, 32'h0,       0, 32'h0,        0, 32'h0,         0, 32'h184,       0, 32'h300);
        add(32'h140,     0, 32'h0,       0, 32'h0,        0, 32'h0,         1, 32'h300,       0, 32'h300);
        // counter walks down to 00 and saturates, then climbs back
        add(32'h140,     1, 32'h140,     0, 32'h0,        0, 32'h144,       1, 32'h300,       0, 32'h300);
        add(32'h140,     1, 32'h140,     0, 32'h0,        0, 32'h144,       0, 32'h144,       0, 32'h300);
        add(32'h140,     1, 32'h140,     0, 32'h0,        0, 32'h144,       0, 32'h144,       0, 32'h300);
        add(32'h140,     1, 32'h140,     1, 32'h300,      0, 32'h144,       0, 32'h144,       1, 32'h300);
        add(32'h140,     1, 32'h140,     1, 32'h300,      0, 32'h144,       0, 32'h144,       1, 32'h300);
        add(32'h140,     0, 32'h0,       0, 32'h0,        0, 32'h0,         1, 32'h300,       0, 32'h300);
        // fall-through wraps modulo 2^32
        add(32'hFFFF_FFFC, 0, 32'h0,     0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h300);
        // a second index is independent
        add(32'h104,     1, 32'h104,     1, 32'h400,      0, 32'h108,       0, 32'h108,       1, 32'h400);
        add(32'h104,     0, 32'h0,       0, 32'h0,        0, 32'h0,         1, 32'h400,       0, 32'h400);
        add(32'h140,     0, 32'h0,       0, 32'h0,        0, 32'h0,         1, 32'h300,       0, 32'h400);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_mispredict", {31'b0, mispredict}, 32'h0);
        check("reset_correct_pc", correct_pc, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[k]) begin
            @(negedge clk);
            fetch_pc        = vq[k].fetch_pc;
            upd_valid       = vq[k].upd_valid;
            upd_pc          = vq[k].upd_pc;
            upd_taken       = vq[k].upd_taken;
            upd_target      = vq[k].upd_target;
            upd_pred_taken  = vq[k].upd_pred_taken;
            upd_pred_target = vq[k].upd_pred_target;
            #1;
            check($sformatf("v%0d_pred_taken", k), {31'b0, pred_taken}, {31'b0, vq[k].exp_pred_taken});
            check($sformatf("v%0d_pred_target", k), pred_target, vq[k].exp_pred_target);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_mispredict", k), {31'b0, mispredict}, {31'b0, vq[k].exp_mispredict});
            check($sformatf("v%0d_correct_pc", k), correct_pc, vq[k].exp_correct_pc);
            if (vq[k].upd_valid) exp_branches++;
            if (vq[k].exp_mispredict) exp_misp++;
        end

`ifdef BP_STATS_EN
        check("stat_branches", stat_branches, 32'(exp_branches));
        check("stat_mispredicts", stat_mispredicts, 32'(exp_misp));
`endif

        // Reset coincident with a would-be mispredicting allocation
        @(negedge clk);
        rst_n = 1'b0;
        fetch_pc = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h1C0; upd_taken = 1'b1; upd_target = 32'h500;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h1C4;
        @(posedge clk);
        #1;
        check("rst_upd_mispredict", {31'b0, mispredict}, 32'h0);
        check("rst_upd_correct_pc", correct_pc, 32'h0);
`ifdef BP_STATS_EN
        check("rst_stat_branches", stat_branches, 32'h0);
        check("rst_stat_mispredicts", stat_mispredicts, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        fetch_pc = 32'h1C0;
        #1;
        check("rst_no_alloc_taken", {31'b0, pred_taken}, 32'h0);
        check("rst_no_alloc_target", pred_target, 32'h1C4);
        fetch_pc = 32'h140;
        #1;
        check("rst_cleared_140_taken", {31'b0, pred_taken}, 32'h0);
        check("rst_cleared_140_target", pred_target, 32'h144);
        fetch_pc = 32'h104;
        #1;
        check("rst_cleared_104_target", pred_target, 32'h108);
        @(posedge clk);
        #1;
        check("post_rst_mispredict", {31'b0, mispredict}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
